fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch queue between the fetch stage (PC register, instruction memory, PC+4 adder) and the fetch/issue pipeline register.
- Buffers up to DEPTH {pc, instr} pairs with a valid/ready handshake on each side.
- Fetch keeps running while issue is stalled; issue sees a steady, registered instruction stream.
- A single flush input discards all buffered entries on control-flow redirect.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
PC_W, 32, PC width in bits
INSTR_W, 32, instruction width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
push_valid_fq_i  input  1  fetch offers an entry this cycle
push_ready_fq_o  output  1  queue can accept an entry (not full)
pc_fq_i  input  PC_W  PC of offered instruction (next sequential PC, as fed to the issue register)
instr_fq_i  input  INSTR_W  offered instruction word from instruction memory
pop_ready_fq_i  input  1  issue stage accepts the head entry (deasserted on issue stall)
pop_valid_fq_o  output  1  head entry is valid
pc_fq_o  output  PC_W  PC of head entry
instr_fq_o  output  INSTR_W  instruction of head entry
flush_fq_i  input  1  discard all entries (redirect)
count_fq_o  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (asynchronous, active-high): rd_ptr = 0, wr_ptr = 0, count = 0, state EMPTY. Outputs during and after reset: push_ready_fq_o = 1, pop_valid_fq_o = 0, pc_fq_o = 0, instr_fq_o = 0, count_fq_o = 0. Storage contents are not reset.
- Push fires when push_valid_fq_i && push_ready_fq_o. Entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop fires when pop_valid_fq_o && pop_ready_fq_i. rd_ptr increments modulo DEPTH.
- Outputs:
  - push_ready_fq_o = (count != DEPTH).
  - pop_valid_fq_o = (count != 0).
  - pc_fq_o / instr_fq_o = storage[rd_ptr] when pop_valid_fq_o is 1, else 0.
- Latency: an entry pushed at edge N is visible on the pop side in the cycle after edge N. Minimum latency is 1 cycle; there is no fall-through.
- State machine (derived from count):
  - EMPTY (count 0): push -> PARTIAL.
  - PARTIAL: push only -> count+1, which becomes FULL when count reaches DEPTH. Pop only -> count-1, which becomes EMPTY when count reaches 0. Push and pop together -> count unchanged.
  - FULL: pop -> PARTIAL. push_ready_fq_o = 0 even if a pop fires in the same cycle; there is no combinational ready path from pop_ready_fq_i.
- Simultaneous push and pop in PARTIAL: both take effect and count is unchanged. Order is preserved: the popped entry is the old head.
- Flush priority: flush_fq_i = 1 overrides push and pop in the same cycle.
  - Both pointers go to 0 and count goes to 0; the offered entry is dropped.
  - Next cycle: pop_valid_fq_o = 0, push_ready_fq_o = 1.
  - pop_valid_fq_o is not gated combinationally by flush_fq_i.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Order is maintained across any number of wraps.
- Pushes when full and pops when empty are ignored by the handshake; no state change. An assertion flags push_valid_fq_i held with push_ready_fq_o low for more than 64 cycles, under simulation only.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined: when count == 0 and push_valid_fq_i == 1, pop_valid_fq_o = 1 and pc_fq_o / instr_fq_o = pc_fq_i / instr_fq_i combinationally.
  - If pop_ready_fq_i == 1, the entry is consumed directly and not written; count stays 0. This gives zero-cycle latency.
  - If pop_ready_fq_i == 0, the entry is written normally.
  - flush_fq_i = 1 suppresses the bypass (pop_valid_fq_o = 0).
- Undefined: strictly registered, 1-cycle minimum latency as in Behaviour.

Test Plan:
- Reset mid-stream (count 3, reset pulsed asynchronously between edges) -> outputs immediately pop_valid_fq_o = 0, count_fq_o = 0, push_ready_fq_o = 1, pc_fq_o = 0.
- Push pc 0x4/0x8/0xC/0x10 (instrs 0x20080001..4) with pop_ready_fq_i = 0, DEPTH 4 -> count_fq_o = 4, push_ready_fq_o = 0; a 5th push (pc 0x14) is ignored. With pop_ready_fq_i = 1, pops return 0x4, 0x8, 0xC, 0x10 in order, then pop_valid_fq_o = 0.
- Continuous push and pop for 10 entries (pc 0x4 + 4k) -> count_fq_o steady at 1 after the first cycle, pointers wrap twice, output sequence matches input with 1-cycle latency.
- Full queue, pop_ready_fq_i = 1 and push_valid_fq_i = 1 in the same cycle -> pop fires, push is not accepted (push_ready_fq_o = 0), count_fq_o = 3; the next cycle the push is accepted and count returns to 4.
- Count 2, flush_fq_i = 1 with push_valid_fq_i = 1 and pop_ready_fq_i = 1 -> next cycle count_fq_o = 0, pop_valid_fq_o = 0; the pushed entry is absent from later pops.
- Bypass, with and without FETCH_QUEUE_BYPASS_EN: empty queue, push pc 0x40 with pop_ready_fq_i = 1.
  - Defined -> pop_valid_fq_o = 1 with pc_fq_o = 0x40 in the same cycle, count stays 0.
  - Undefined -> pc 0x40 appears the next cycle.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: push side from the fetch stage, pop side to the issue register.
// master = fetch/issue side driving the queue, slave = the queue itself.
interface fetch_queue_if #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
);
  logic                         push_valid_fq_i;
  logic                         push_ready_fq_o;
  logic [PC_W-1:0]              pc_fq_i;
  logic [INSTR_W-1:0]           instr_fq_i;
  logic                         pop_ready_fq_i;
  logic                         pop_valid_fq_o;
  logic [PC_W-1:0]              pc_fq_o;
  logic [INSTR_W-1:0]           instr_fq_o;
  logic                         flush_fq_i;
  logic [$clog2(DEPTH+1)-1:0]   count_fq_o;

  modport master (
    output push_valid_fq_i, pc_fq_i, instr_fq_i, pop_ready_fq_i, flush_fq_i,
    input  push_ready_fq_o, pop_valid_fq_o, pc_fq_o, instr_fq_o, count_fq_o
  );

  modport slave (
    input  push_valid_fq_i, pc_fq_i, instr_fq_i, pop_ready_fq_i, flush_fq_i,
    output push_ready_fq_o, pop_valid_fq_o, pc_fq_o, instr_fq_o, count_fq_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry {pc, instr} FIFO between fetch and issue.
// Registered pop side (1-cycle minimum latency); flush empties the queue.
// Optional macro FETCH_QUEUE_BYPASS_EN: zero-latency pass-through when empty.
module fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.slave fq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic bypass_vis;
  logic bypass_take;
  logic wr_en;
  logic rd_en;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_vis = (state_q == EMPTY) && fq.push_valid_fq_i && !fq.flush_fq_i;
`else
  assign bypass_vis = 1'b0;
`endif
  assign bypass_take = bypass_vis && fq.pop_ready_fq_i;

  // Handshake qualifiers; flush overrides both sides, bypassed entries skip storage.
  assign wr_en = fq.push_valid_fq_i && (state_q != FULL) && !fq.flush_fq_i && !bypass_take;
  assign rd_en = fq.pop_ready_fq_i && (state_q != EMPTY) && !fq.flush_fq_i;

  // State register: occupancy, pointers and FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= fq.pc_fq_i;
      instr_mem[wr_ptr_q] <= fq.instr_fq_i;
    end
  end

  // Next-state: pointer/count update, state derived from the new count.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (fq.flush_fq_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    if (count_d == '0)            state_d = EMPTY;
    else if (count_d == CNT_FULL) state_d = FULL;
    else                          state_d = PARTIAL;
  end

  // Outputs: ready from state only, head data zeroed while not valid.
  always_comb begin
    fq.push_ready_fq_o = (state_q != FULL);
    fq.pop_valid_fq_o  = 1'b0;
    fq.pc_fq_o         = '0;
    fq.instr_fq_o      = '0;
    if (bypass_vis) begin
      fq.pop_valid_fq_o = 1'b1;
      fq.pc_fq_o        = fq.pc_fq_i;
      fq.instr_fq_o     = fq.instr_fq_i;
    end else if (state_q != EMPTY) begin
      fq.pop_valid_fq_o = 1'b1;
      fq.pc_fq_o        = pc_mem[rd_ptr_q];
      fq.instr_fq_o     = instr_mem[rd_ptr_q];
    end
  end

  assign fq.count_fq_o = count_q;

`ifndef SYNTHESIS
  int unsigned stall_cnt;

  // Consecutive cycles the fetch side has been held off by a full queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          stall_cnt <= 0;
    else if (fq.push_valid_fq_i && !fq.push_ready_fq_o) stall_cnt <= stall_cnt + 32'd1;
    else                                                stall_cnt <= 0;
  end

  // Flag a push held off for more than 64 cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (stall_cnt <= 64) else $error("fetch_queue: push stalled over 64 cycles");
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH 4); expectations follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_queue_if #(.DEPTH(4), .PC_W(32), .INSTR_W(32)) fq_bus ();

  fetch_queue #(.DEPTH(4), .PC_W(32), .INSTR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic pr, input logic fl);
    fq_bus.push_valid_fq_i = pv;
    fq_bus.pc_fq_i         = pc;
    fq_bus.instr_fq_i      = ins;
    fq_bus.pop_ready_fq_i  = pr;
    fq_bus.flush_fq_i      = fl;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("rst_push_ready", 32'(fq_bus.push_ready_fq_o), 32'd1);
    check("rst_pop_valid",  32'(fq_bus.pop_valid_fq_o),  32'd0);
    check("rst_count",      32'(fq_bus.count_fq_o),      32'd0);
    check("rst_pc",         fq_bus.pc_fq_o,              32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Fill to DEPTH with issue stalled, then an ignored 5th push.
    drive(1'b1, 32'h4, 32'h20080001, 1'b0, 1'b0);
    tick();
    check("fill_first_pc", fq_bus.pc_fq_o, 32'h4);
    drive(1'b1, 32'h8, 32'h20080002, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hC, 32'h20080003, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h10, 32'h20080004, 1'b0, 1'b0);
    tick();
    check("full_count",      32'(fq_bus.count_fq_o),      32'd4);
    check("full_push_ready", 32'(fq_bus.push_ready_fq_o), 32'd0);
    drive(1'b1, 32'h14, 32'h20080005, 1'b0, 1'b0);
    tick();
    check("full_ignore_count", 32'(fq_bus.count_fq_o), 32'd4);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_pc",    fq_bus.pc_fq_o,    32'h4 + 32'(4 * k));
      check("drain_instr", fq_bus.instr_fq_o, 32'h20080001 + 32'(k));
      tick();
    end
    check("drain_valid", 32'(fq_bus.pop_valid_fq_o), 32'd0);
    check("drain_count", 32'(fq_bus.count_fq_o),     32'd0);

    // Streaming: 10 entries with push and pop every cycle (pointers wrap twice).
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h4 + 32'(4 * k), 32'h1000 + 32'(k), 1'b1, 1'b0);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      check("stream_byp_pc",    fq_bus.pc_fq_o,              32'h4 + 32'(4 * k));
      check("stream_byp_count", 32'(fq_bus.count_fq_o),      32'd0);
      tick();
`else
      tick();
      check("stream_pc",    fq_bus.pc_fq_o,         32'h4 + 32'(4 * k));
      check("stream_instr", fq_bus.instr_fq_o,      32'h1000 + 32'(k));
      check("stream_count", 32'(fq_bus.count_fq_o), 32'd1);
`endif
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("stream_end_count", 32'(fq_bus.count_fq_o), 32'd0);

    // Full queue with simultaneous push and pop: only the pop fires.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 32'h2000 + 32'(k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h200, 32'h3000, 1'b1, 1'b0);
    #1;
    check("fullpp_ready", 32'(fq_bus.push_ready_fq_o), 32'd0);
    tick();
    check("fullpp_count", 32'(fq_bus.count_fq_o), 32'd3);
    check("fullpp_head",  fq_bus.pc_fq_o,         32'h104);
    drive(1'b1, 32'h200, 32'h3000, 1'b0, 1'b0);
    tick();
    check("fullpp_refill", 32'(fq_bus.count_fq_o), 32'd4);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    check("fullpp_pop0", fq_bus.pc_fq_o, 32'h104);
    tick();
    check("fullpp_pop1", fq_bus.pc_fq_o, 32'h108);
    tick();
    check("fullpp_pop2", fq_bus.pc_fq_o, 32'h10C);
    tick();
    check("fullpp_pop3", fq_bus.pc_fq_o, 32'h200);
    tick();
    check("fullpp_empty", 32'(fq_bus.pop_valid_fq_o), 32'd0);

    // Flush at count 2 with push and pop offered.
    drive(1'b1, 32'h300, 32'h4000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h304, 32'h4001, 1'b0, 1'b0);
    tick();
    check("flush_pre_count", 32'(fq_bus.count_fq_o), 32'd2);
    drive(1'b1, 32'h308, 32'h4002, 1'b1, 1'b1);
    #1;
    check("flush_valid_ungated", 32'(fq_bus.pop_valid_fq_o), 32'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("flush_count", 32'(fq_bus.count_fq_o),      32'd0);
    check("flush_valid", 32'(fq_bus.pop_valid_fq_o),  32'd0);
    check("flush_ready", 32'(fq_bus.push_ready_fq_o), 32'd1);
    drive(1'b1, 32'h30C, 32'h4003, 1'b0, 1'b0);
    tick();
    check("flush_after_head",  fq_bus.pc_fq_o,         32'h30C);
    check("flush_after_count", 32'(fq_bus.count_fq_o), 32'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("flush_after_empty", 32'(fq_bus.count_fq_o), 32'd0);

    // Empty queue, push 0x40 with issue ready.
    drive(1'b1, 32'h40, 32'h5000, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_valid", 32'(fq_bus.pop_valid_fq_o), 32'd1);
    check("byp_pc",    fq_bus.pc_fq_o,             32'h40);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    check("byp_count", 32'(fq_bus.count_fq_o),     32'd0);
    check("byp_after", 32'(fq_bus.pop_valid_fq_o), 32'd0);
`else
    check("nobyp_valid", 32'(fq_bus.pop_valid_fq_o), 32'd0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    check("nobyp_pc",    fq_bus.pc_fq_o,         32'h40);
    check("nobyp_count", 32'(fq_bus.count_fq_o), 32'd1);
    tick();
    check("nobyp_empty", 32'(fq_bus.count_fq_o), 32'd0);
`endif

    // Asynchronous reset between edges at count 3.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h500 + 32'(4 * k), 32'h6000 + 32'(k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("mid_pre_count", 32'(fq_bus.count_fq_o), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    check("mid_valid", 32'(fq_bus.pop_valid_fq_o),  32'd0);
    check("mid_count", 32'(fq_bus.count_fq_o),      32'd0);
    check("mid_ready", 32'(fq_bus.push_ready_fq_o), 32'd1);
    check("mid_pc",    fq_bus.pc_fq_o,              32'd0);
    #1;
    reset = 1'b0;
    tick();
    check("post_reset_count", 32'(fq_bus.count_fq_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
